// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg : shared widths, HALT opcode and state encoding           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fetch_pkg;

  localparam int         ADDR_W_DEFAULT      = 8;
  localparam int         INSTR_W_DEFAULT     = 16;
  localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_if : control inputs, memory port and decode outputs           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int INSTR_W = INSTR_W_DEFAULT
);

  logic               start;
  logic [ADDR_W-1:0]  start_addr;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_addr;
  logic [INSTR_W-1:0] curr_instr;
  logic [ADDR_W-1:0]  curr_pc;
  logic               instr_valid;
  logic               halted;
  logic [15:0]        fetch_count;

  modport master (
    output start, start_addr, stall, redirect_valid, redirect_addr, instr,
    input  instr_addr, curr_instr, curr_pc, instr_valid, halted, fetch_count
  );

  modport slave (
    input  start, start_addr, stall, redirect_valid, redirect_addr, instr,
    output instr_addr, curr_instr, curr_pc, instr_valid, halted, fetch_count
  );

endinterface
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_controller : IDLE/RUN/HALT instruction fetch with stall,      |
// | redirect and saturating issue counter.       Rev 1.0                |
// +--------------------------------------------------------------------+
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int         ADDR_W      = ADDR_W_DEFAULT,
  parameter int         INSTR_W     = INSTR_W_DEFAULT,
  parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  fetch_if.slave    bus
);

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  addr_q, addr_nx;
  logic [ADDR_W-1:0]  pc_q, pc_nx;
  logic [INSTR_W-1:0] ir_q, ir_nx;
  logic               valid_q, valid_nx;
  logic [15:0]        cnt_q, cnt_nx;
  logic               halt_word;

  assign halt_word = (bus.instr[INSTR_W-1 -: 4] == HALT_OPCODE);

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    pc_nx    = pc_q;
    ir_nx    = ir_q;
    valid_nx = valid_q;
    cnt_nx   = cnt_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          addr_nx  = bus.start_addr;
          valid_nx = 1'b0;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        // Redirect outranks stall and discards whatever word is on instr.
        if (bus.redirect_valid) begin
          addr_nx  = bus.redirect_addr;
          valid_nx = 1'b0;
        end else if (!bus.stall) begin
          ir_nx    = bus.instr;
          pc_nx    = addr_q;
          valid_nx = 1'b1;
          cnt_nx   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (halt_word) begin
            state_nx = ST_HALT;
          end else begin
            addr_nx = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_HALT: begin
        valid_nx = 1'b0;
        if (bus.start) begin
          addr_nx  = bus.start_addr;
          state_nx = ST_RUN;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      pc_q    <= pc_nx;
      ir_q    <= ir_nx;
      valid_q <= valid_nx;
      cnt_q   <= cnt_nx;
    end
  end

  assign bus.instr_addr  = addr_q;
  assign bus.curr_instr  = ir_q;
  assign bus.curr_pc     = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = (state == ST_HALT);
  assign bus.fetch_count = cnt_q;

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter ADDR_W, 8, instruction-address / PC width.
REQ-002 Parameter INSTR_W, 16, instruction word width.
REQ-003 Parameter HALT_OPCODE, 4'hF, value of instr[INSTR_W-1:INSTR_W-4] that denotes HALT.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-006 start  input  1  one-cycle pulse; begins fetching from start_addr.
REQ-007 start_addr  input  ADDR_W  first fetch address on start.
REQ-008 stall  input  1  downstream cannot accept; freeze fetch.
REQ-009 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_addr  input  ADDR_W  redirect target.
REQ-011 instr  input  INSTR_W  instruction memory read data, combinational from instr_addr.
REQ-012 instr_addr  output  ADDR_W  instruction memory address.
REQ-013 curr_instr  output  INSTR_W  instruction register to decode.
REQ-014 curr_pc  output  ADDR_W  address of curr_instr.
REQ-015 instr_valid  output  1  curr_instr is a live (non-flushed) instruction.
REQ-016 halted  output  1  controller is in HALT.
REQ-017 fetch_count  output  16  saturating count of valid instructions issued.

Function
REQ-018 States: IDLE, RUN, HALT; encoding from the shared package.
REQ-019 IDLE: outputs hold; start=1 -> instr_addr<=start_addr, instr_valid<=0, next RUN.
REQ-020 RUN, redirect_valid=1: instr_addr<=redirect_addr, instr_valid<=0, curr_instr/curr_pc hold; redirect outranks stall.
REQ-021 RUN, stall=1, no redirect: instr_addr, curr_instr, curr_pc, instr_valid, fetch_count all hold.
REQ-022 RUN, no stall/redirect: curr_instr<=instr, curr_pc<=instr_addr, instr_valid<=1, instr_addr<=instr_addr+1, fetch_count+1 (saturate at 16'hFFFF).
REQ-023 Fetch latency: word at address A appears on curr_instr exactly one un-stalled cycle after instr_addr=A.
REQ-024 instr_addr increment wraps modulo 2^ADDR_W (8'hFF -> 8'h00); no flag, no stop.
REQ-025 RUN latch per REQ-022 of a word whose top 4 bits equal HALT_OPCODE: word issued with instr_valid=1, instr_addr holds (not incremented), next HALT.
REQ-026 HALT: halted=1; instr_valid<=0 on first HALT cycle; instr_addr, curr_instr, curr_pc hold; stall and redirect ignored.
REQ-027 HALT, start=1: behave per REQ-019 (halted<=0, next RUN).
REQ-028 start ignored in RUN; redirect/stall ignored in IDLE.
REQ-029 Redirect same cycle as a HALT-opcode instr: redirect wins, HALT word discarded, stay RUN.
REQ-030 halted asserted iff state==HALT; no combinational path from inputs to any output.

Reset
REQ-031 rst=0 at a rising edge: state<=IDLE, instr_addr<=0, curr_instr<=0, curr_pc<=0, instr_valid<=0, halted<=0, fetch_count<=0.
REQ-032 Reset takes priority over every other input, including mid-RUN, mid-stall, or during HALT.
REQ-033 Every register has a defined reset value; no initial-block-only initialisation.

Structure
REQ-034 Package fetch_pkg holds ADDR_W/INSTR_W defaults, HALT_OPCODE, and the state enum typedef.
REQ-035 Single flat module; no sub-module (PC incrementer inline).

Verification
REQ-036 Reset, start with start_addr=8'h10, memory returns 16'h1000+addr -> curr_instr 16'h1010,16'h1011,16'h1012 on consecutive cycles, curr_pc 10,11,12, fetch_count=3.
REQ-037 Stall high 3 cycles while curr_instr=16'h1012 -> all outputs frozen 3 cycles, next cycle curr_instr=16'h1013.
REQ-038 redirect to 8'h40 with stall=1 same cycle -> next cycle instr_valid=0, instr_addr=8'h40; following cycle curr_instr=16'h1040, valid=1.
REQ-039 Start at 8'hFE -> curr_pc sequence FE, FF, 00; instr_addr wraps to 00 then 01.
REQ-040 Word 16'hF123 at 8'h05 -> issued valid one cycle, then halted=1, instr_valid=0, instr_addr=05 held; start at 8'h20 resumes at 20.
REQ-041 rst=0 asserted mid-RUN with stall=1 -> all outputs zero next edge, state IDLE; no fetch until start.
